// File: rtl/mem_arbiter.sv
// Two-requester arbiter sharing one backend memory port between instruction fetch and data memory.
// One transaction outstanding at a time; ties alternate based on the previous grant.
module mem_arbiter #(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned WORD_W      = 32,
    parameter int unsigned MEM_COUNT_W = 2,
    parameter int unsigned MEM_CODE_W  = 2
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   i_if_req,
    input  logic [ADDR_W-1:0]      i_if_addr,
    output logic [WORD_W-1:0]      o_if_rd_data,
    output logic [MEM_CODE_W-1:0]  o_if_code,
    output logic                   o_if_valid,
    input  logic                   i_dm_req,
    input  logic [ADDR_W-1:0]      i_dm_addr,
    input  logic [WORD_W-1:0]      i_dm_wr_data,
    input  logic                   i_dm_wr_en,
    input  logic [MEM_COUNT_W-1:0] i_dm_count,
    output logic [WORD_W-1:0]      o_dm_rd_data,
    output logic [MEM_CODE_W-1:0]  o_dm_code,
    output logic                   o_dm_valid,
    output logic                   o_bus_req,
    output logic [ADDR_W-1:0]      o_bus_addr,
    output logic [WORD_W-1:0]      o_bus_wr_data,
    output logic                   o_bus_wr_en,
    output logic [MEM_COUNT_W-1:0] o_bus_count,
    input  logic                   i_bus_ready,
    input  logic                   i_bus_rvalid,
    input  logic [WORD_W-1:0]      i_bus_rd_data,
    input  logic [MEM_CODE_W-1:0]  i_bus_code
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    localparam logic GntIf = 1'b0;
    localparam logic GntDm = 1'b1;

    state_e                 state_q, state_d;
    logic                   last_grant_q, last_grant_d;
    logic                   grant_q, grant_d;
    logic                   bus_req_q, bus_req_d;
    logic [ADDR_W-1:0]      bus_addr_q, bus_addr_d;
    logic [WORD_W-1:0]      bus_wr_data_q, bus_wr_data_d;
    logic                   bus_wr_en_q, bus_wr_en_d;
    logic [MEM_COUNT_W-1:0] bus_count_q, bus_count_d;
    logic [WORD_W-1:0]      if_rd_data_q, if_rd_data_d;
    logic [MEM_CODE_W-1:0]  if_code_q, if_code_d;
    logic                   if_valid_q, if_valid_d;
    logic [WORD_W-1:0]      dm_rd_data_q, dm_rd_data_d;
    logic [MEM_CODE_W-1:0]  dm_code_q, dm_code_d;
    logic                   dm_valid_q, dm_valid_d;
    logic                   any_req;
    logic                   pick_dm;

    assign any_req = i_if_req | i_dm_req;
    // On a tie the requester that did not win last time goes next.
    assign pick_dm = i_dm_req & (~i_if_req | (last_grant_q == GntIf));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (any_req)      state_d = StIssue;
            StIssue: if (i_bus_ready)  state_d = StWait;
            StWait:  if (i_bus_rvalid) state_d = StIdle;
            default:                   state_d = StIdle;
        endcase
    end

    always_comb begin
        last_grant_d  = last_grant_q;
        grant_d       = grant_q;
        bus_req_d     = bus_req_q;
        bus_addr_d    = bus_addr_q;
        bus_wr_data_d = bus_wr_data_q;
        bus_wr_en_d   = bus_wr_en_q;
        bus_count_d   = bus_count_q;
        if_rd_data_d  = if_rd_data_q;
        if_code_d     = if_code_q;
        if_valid_d    = 1'b0;
        dm_rd_data_d  = dm_rd_data_q;
        dm_code_d     = dm_code_q;
        dm_valid_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    bus_req_d    = 1'b1;
                    grant_d      = pick_dm ? GntDm : GntIf;
                    last_grant_d = pick_dm ? GntDm : GntIf;
                    if (pick_dm) begin
                        bus_addr_d    = i_dm_addr;
                        bus_wr_data_d = i_dm_wr_data;
                        bus_wr_en_d   = i_dm_wr_en;
                        bus_count_d   = i_dm_count;
                    end else begin
                        bus_addr_d    = i_if_addr;
                        bus_wr_data_d = '0;
                        bus_wr_en_d   = 1'b0;
                        bus_count_d   = {MEM_COUNT_W{1'b1}};
                    end
                end
            end
            StIssue: begin
                if (i_bus_ready) bus_req_d = 1'b0;
            end
            StWait: begin
                if (i_bus_rvalid) begin
                    if (grant_q == GntDm) begin
                        dm_rd_data_d = i_bus_rd_data;
                        dm_code_d    = i_bus_code;
                        dm_valid_d   = 1'b1;
                    end else begin
                        if_rd_data_d = i_bus_rd_data;
                        if_code_d    = i_bus_code;
                        if_valid_d   = 1'b1;
                    end
                end
            end
            default: bus_req_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            last_grant_q  <= GntIf;
            grant_q       <= GntIf;
            bus_req_q     <= 1'b0;
            bus_addr_q    <= '0;
            bus_wr_data_q <= '0;
            bus_wr_en_q   <= 1'b0;
            bus_count_q   <= '0;
            if_rd_data_q  <= '0;
            if_code_q     <= '0;
            if_valid_q    <= 1'b0;
            dm_rd_data_q  <= '0;
            dm_code_q     <= '0;
            dm_valid_q    <= 1'b0;
        end else begin
            last_grant_q  <= last_grant_d;
            grant_q       <= grant_d;
            bus_req_q     <= bus_req_d;
            bus_addr_q    <= bus_addr_d;
            bus_wr_data_q <= bus_wr_data_d;
            bus_wr_en_q   <= bus_wr_en_d;
            bus_count_q   <= bus_count_d;
            if_rd_data_q  <= if_rd_data_d;
            if_code_q     <= if_code_d;
            if_valid_q    <= if_valid_d;
            dm_rd_data_q  <= dm_rd_data_d;
            dm_code_q     <= dm_code_d;
            dm_valid_q    <= dm_valid_d;
        end
    end

    assign o_bus_req     = bus_req_q;
    assign o_bus_addr    = bus_addr_q;
    assign o_bus_wr_data = bus_wr_data_q;
    assign o_bus_wr_en   = bus_wr_en_q;
    assign o_bus_count   = bus_count_q;
    assign o_if_rd_data  = if_rd_data_q;
    assign o_if_code     = if_code_q;
    assign o_if_valid    = if_valid_q;
    assign o_dm_rd_data  = dm_rd_data_q;
    assign o_dm_code     = dm_code_q;
    assign o_dm_valid    = dm_valid_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a backend model drives ready/rvalid and a scoreboard
// queue holds the expected completion for every response the backend returns.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        aresetn = 1'b0;
    logic        i_if_req = 1'b0;
    logic [31:0] i_if_addr = '0;
    logic [31:0] o_if_rd_data;
    logic [1:0]  o_if_code;
    logic        o_if_valid;
    logic        i_dm_req = 1'b0;
    logic [31:0] i_dm_addr = '0;
    logic [31:0] i_dm_wr_data = '0;
    logic        i_dm_wr_en = 1'b0;
    logic [1:0]  i_dm_count = '0;
    logic [31:0] o_dm_rd_data;
    logic [1:0]  o_dm_code;
    logic        o_dm_valid;
    logic        o_bus_req;
    logic [31:0] o_bus_addr;
    logic [31:0] o_bus_wr_data;
    logic        o_bus_wr_en;
    logic [1:0]  o_bus_count;
    logic        i_bus_ready = 1'b0;
    logic        i_bus_rvalid = 1'b0;
    logic [31:0] i_bus_rd_data = '0;
    logic [1:0]  i_bus_code = '0;

    typedef struct packed {
        logic        dm;
        logic [31:0] data;
        logic [1:0]  code;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .i_if_req     (i_if_req),
        .i_if_addr    (i_if_addr),
        .o_if_rd_data (o_if_rd_data),
        .o_if_code    (o_if_code),
        .o_if_valid   (o_if_valid),
        .i_dm_req     (i_dm_req),
        .i_dm_addr    (i_dm_addr),
        .i_dm_wr_data (i_dm_wr_data),
        .i_dm_wr_en   (i_dm_wr_en),
        .i_dm_count   (i_dm_count),
        .o_dm_rd_data (o_dm_rd_data),
        .o_dm_code    (o_dm_code),
        .o_dm_valid   (o_dm_valid),
        .o_bus_req    (o_bus_req),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wr_data(o_bus_wr_data),
        .o_bus_wr_en  (o_bus_wr_en),
        .o_bus_count  (o_bus_count),
        .i_bus_ready  (i_bus_ready),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rd_data(i_bus_rd_data),
        .i_bus_code   (i_bus_code)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Completion monitor: every valid pulse must match the oldest queued response.
    always @(negedge clk) begin
        if (o_if_valid || o_dm_valid) begin
            if (sb_q.size() == 0) begin
                check("unexpected_valid", {62'd0, o_if_valid, o_dm_valid}, 64'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("valid_pair", {62'd0, o_if_valid, o_dm_valid}, {62'd0, ~e.dm, e.dm});
                check("rd_data", e.dm ? o_dm_rd_data : o_if_rd_data, e.data);
                check("code", e.dm ? o_dm_code : o_if_code, e.code);
            end
        end
    end

    // Backend model for one transaction: waits for the request, checks the bus fields in
    // every ISSUE cycle while holding ready low for dly cycles, then answers one cycle later.
    task automatic serve(input int dly, input bit stray, input bit dm, input logic [31:0] addr,
                         input logic [31:0] wd, input logic we, input logic [1:0] cnt,
                         input logic [31:0] rd, input logic [1:0] code, output int lat);
        int t = 0;
        @(negedge clk);
        while (!o_bus_req && t < 20) begin
            @(negedge clk);
            t++;
        end
        lat = t;
        check("bus_req_seen", 64'(o_bus_req), 64'd1);
        for (int i = 0; i <= dly; i++) begin
            check("issue_req", 64'(o_bus_req), 64'd1);
            check("issue_addr", 64'(o_bus_addr), 64'(addr));
            check("issue_wr_data", 64'(o_bus_wr_data), 64'(wd));
            check("issue_wr_en", 64'(o_bus_wr_en), 64'(we));
            check("issue_count", 64'(o_bus_count), 64'(cnt));
            i_bus_ready  = (i == dly);
            i_bus_rvalid = stray && (i == 0) && (dly > 0);
            i_bus_rd_data = 32'hFFFF_0000;
            @(negedge clk);
        end
        i_bus_ready  = 1'b0;
        i_bus_rvalid = 1'b0;
        check("wait_req_low", 64'(o_bus_req), 64'd0);
        i_bus_rvalid  = 1'b1;
        i_bus_rd_data = rd;
        i_bus_code    = code;
        sb_q.push_back('{dm: dm, data: rd, code: code});
        @(negedge clk);
        i_bus_rvalid = 1'b0;
        i_bus_code   = '0;
    endtask

    initial begin
        int lat;
        #2;
        check("rst_outputs", {o_bus_req, o_bus_addr, o_bus_wr_data, o_bus_wr_en, o_bus_count,
                              o_if_valid, o_dm_valid, o_if_code, o_dm_code}, 64'd0);
        check("rst_rd_data", {o_if_rd_data, o_dm_rd_data}, 64'd0);
        @(negedge clk);
        aresetn = 1'b1;
        @(negedge clk);

        // Single fetch, minimum latency
        i_if_req  = 1'b1;
        i_if_addr = 32'h100;
        serve(0, 0, 0, 32'h100, 32'h0, 1'b0, 2'b11, 32'hDEADBEEF, 2'd0, lat);
        check("fetch_latency", 64'(lat), 64'd0);
        check("fetch_if_valid", 64'(o_if_valid), 64'd1);
        check("fetch_dm_valid", 64'(o_dm_valid), 64'd0);
        i_if_req = 1'b0;
        @(negedge clk);

        // Contention: DM wins the first tie, then strict alternation
        i_if_addr    = 32'h200;
        i_dm_addr    = 32'h300;
        i_dm_wr_data = 32'h5555_AAAA;
        i_dm_wr_en   = 1'b0;
        i_dm_count   = 2'd1;
        i_if_req     = 1'b1;
        i_dm_req     = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0)
                serve(0, 0, 1, 32'h300, 32'h5555_AAAA, 1'b0, 2'd1, 32'hD000_0000 + k, 2'd0, lat);
            else
                serve(0, 0, 0, 32'h200, 32'h0, 1'b0, 2'b11, 32'h1000_0000 + k, 2'd0, lat);
            check("contention_latency", 64'(lat), 64'd0);
        end
        i_if_req = 1'b0;
        i_dm_req = 1'b0;
        @(negedge clk);

        // Store with three cycles of backpressure; inputs wiggled mid-transaction are ignored
        i_dm_addr    = 32'h40;
        i_dm_wr_data = 32'h12345678;
        i_dm_wr_en   = 1'b1;
        i_dm_count   = 2'd2;
        i_dm_req     = 1'b1;
        @(negedge clk);
        i_dm_addr    = 32'hBAD0;
        i_dm_wr_data = 32'h0;
        i_if_req     = 1'b1;
        serve(3, 0, 1, 32'h40, 32'h12345678, 1'b1, 2'd2, 32'h0, 2'd0, lat);
        i_dm_req = 1'b0;
        i_if_req = 1'b0;
        @(negedge clk);
        // The IF request raised during the store was never visible in IDLE
        check("ignored_if_req", 64'(o_bus_req), 64'd0);

        // Stray rvalid during ISSUE, then an error completion
        i_dm_addr  = 32'h80;
        i_dm_wr_en = 1'b0;
        i_dm_count = 2'd0;
        i_dm_req   = 1'b1;
        serve(1, 1, 1, 32'h80, 32'h0, 1'b0, 2'd0, 32'hCAFE0001, 2'd2, lat);
        check("err_dm_code", 64'(o_dm_code), 64'd2);
        check("err_dm_valid", 64'(o_dm_valid), 64'd1);
        i_dm_req = 1'b0;
        @(negedge clk);

        // Reset in WAIT abandons the transaction
        i_if_addr = 32'h500;
        i_if_req  = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_issue_req", 64'(o_bus_req), 64'd1);
        i_bus_ready = 1'b1;
        @(negedge clk);
        i_bus_ready = 1'b0;
        check("rst_wait_req", 64'(o_bus_req), 64'd0);
        #2;
        aresetn  = 1'b0;
        i_if_req = 1'b0;
        #1;
        check("midrst_outputs", {o_bus_req, o_bus_addr, o_bus_wr_data, o_bus_wr_en, o_bus_count,
                                 o_if_valid, o_dm_valid, o_if_code, o_dm_code}, 64'd0);
        check("midrst_rd_data", {o_if_rd_data, o_dm_rd_data}, 64'd0);
        @(negedge clk);
        aresetn       = 1'b1;
        i_bus_rvalid  = 1'b1;
        i_bus_rd_data = 32'hBADBAD;
        @(negedge clk);
        i_bus_rvalid = 1'b0;
        check("late_rvalid", {62'd0, o_if_valid, o_dm_valid}, 64'd0);
        @(negedge clk);
        i_if_addr = 32'h600;
        i_if_req  = 1'b1;
        serve(0, 0, 0, 32'h600, 32'h0, 1'b0, 2'b11, 32'h11112222, 2'd1, lat);
        check("post_rst_latency", 64'(lat), 64'd0);
        i_if_req = 1'b0;
        repeat (3) @(negedge clk);

        check("sb_drained", 64'(sb_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

endmodule
